// File: rtl/game_controller_if.sv
// Counter link: the bus between the game controller and the multimode counter.
// Latency: none, wires only.
// Backpressure: none, the counter always accepts a load strobe.
// Ports (master = controller side):
//   controlValue  [1:0]       mode to counter
//   initialValue  [WIDTH-1:0] load value to counter
//   INIT                      one-cycle load strobe
//   WINNER / LOSER            counter outcome flags (levels)
interface game_controller_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       controlValue;
  logic [WIDTH-1:0] initialValue;
  logic             INIT;
  logic             WINNER;
  logic             LOSER;

  modport master (
    output controlValue,
    output initialValue,
    output INIT,
    input  WINNER,
    input  LOSER
  );

  modport slave (
    input  controlValue,
    input  initialValue,
    input  INIT,
    output WINNER,
    output LOSER
  );
endinterface

// File: rtl/game_controller.sv
// Round sequencer/scorekeeper driving a multimode counter: loads a seed, relays mode, tallies outcomes.
// Latency: start -> INIT 1 cycle; outcome edge -> tally 1 cycle, -> next INIT or gameOver 2 cycles.
// Backpressure: none; start is only honoured in IDLE/OVER, outcome flags only score while in RUN.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, seed         new-game request and the counter seed latched with it
//   modeSelect          player's mode request, forwarded while a round runs
//   cnt (master)        counter link: controlValue, initialValue, INIT out; WINNER, LOSER in
//   winScore, loseScore round tallies
//   gameOver, playerWon game finished / which tally reached TARGET
//   busy                a game round is in progress (LOAD, RUN, SCORE)
module game_controller #(
  parameter int WIDTH      = 4,
  parameter int SCORE_BITS = 4,
  parameter int TARGET     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  input  logic [1:0]            modeSelect,
  game_controller_if.master     cnt,
  output logic [SCORE_BITS-1:0] winScore,
  output logic [SCORE_BITS-1:0] loseScore,
  output logic                  gameOver,
  output logic                  playerWon,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    SCORE = 3'd3,
    OVER  = 3'd4
  } state_e;

  localparam logic [SCORE_BITS-1:0] TARGET_S = SCORE_BITS'(TARGET);
  localparam logic [SCORE_BITS-1:0] ONE_S    = SCORE_BITS'(1);

  state_e                state_q, state_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [WIDTH-1:0]      ival_q, ival_d;
  logic                  init_q, init_d;
  logic [SCORE_BITS-1:0] win_q, win_d;
  logic [SCORE_BITS-1:0] lose_q, lose_d;
  logic                  over_q, over_d;
  logic                  won_q, won_d;
  logic                  busy_q, busy_d;
  logic                  win_prev_q, win_prev_d;
  logic                  lose_prev_q, lose_prev_d;

  logic win_rise;
  logic lose_rise;

  // Edge history runs in every state so a flag already high when a round
  // starts is never mistaken for a fresh outcome.
  assign win_rise  = cnt.WINNER & ~win_prev_q;
  assign lose_rise = cnt.LOSER & ~lose_prev_q;

  always_comb begin
    state_d     = state_q;
    ival_d      = ival_q;
    win_d       = win_q;
    lose_d      = lose_q;
    won_d       = won_q;
    win_prev_d  = cnt.WINNER;
    lose_prev_d = cnt.LOSER;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = LOAD;
          ival_d  = seed;
          win_d   = '0;
          lose_d  = '0;
          won_d   = 1'b0;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        // WINNER has priority; a coincident LOSER edge is dropped.
        if (win_rise) begin
          win_d   = win_q + ONE_S;
          state_d = SCORE;
        end else if (lose_rise) begin
          lose_d  = lose_q + ONE_S;
          state_d = SCORE;
        end
      end
      SCORE: begin
        if (win_q == TARGET_S) begin
          state_d = OVER;
          won_d   = 1'b1;
        end else if (lose_q == TARGET_S) begin
          state_d = OVER;
          won_d   = 1'b0;
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    ctrl_d = (state_d == RUN) ? modeSelect : 2'd0;
    init_d = (state_d == LOAD);
    over_d = (state_d == OVER);
    busy_d = (state_d == LOAD) || (state_d == RUN) || (state_d == SCORE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      ival_q      <= '0;
      init_q      <= 1'b0;
      win_q       <= '0;
      lose_q      <= '0;
      over_q      <= 1'b0;
      won_q       <= 1'b0;
      busy_q      <= 1'b0;
      win_prev_q  <= 1'b0;
      lose_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      ival_q      <= ival_d;
      init_q      <= init_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      over_q      <= over_d;
      won_q       <= won_d;
      busy_q      <= busy_d;
      win_prev_q  <= win_prev_d;
      lose_prev_q <= lose_prev_d;
    end
  end

  assign cnt.controlValue = ctrl_q;
  assign cnt.initialValue = ival_q;
  assign cnt.INIT         = init_q;
  assign winScore         = win_q;
  assign loseScore        = lose_q;
  assign gameOver         = over_q;
  assign playerWon        = won_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios plus a randomized run against a round-level model.
// Latency: inputs change on the falling edge, outputs are read on the falling edge after each rising edge.
// Backpressure: not applicable.
module tb_game_controller;
  localparam int WIDTH  = 4;
  localparam int SB     = 4;
  localparam int TARGET = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, wnr, lsr;
  logic [WIDTH-1:0] seed;
  logic [1:0]       mode_sel;
  logic [SB-1:0]    win_score, lose_score;
  logic             game_over, player_won, busy;

  game_controller_if #(.WIDTH(WIDTH)) cnt_if ();
  assign cnt_if.WINNER = wnr;
  assign cnt_if.LOSER  = lsr;

  game_controller #(.WIDTH(WIDTH), .SCORE_BITS(SB), .TARGET(TARGET)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .modeSelect(mode_sel),
    .cnt(cnt_if), .winScore(win_score), .loseScore(lose_score),
    .gameOver(game_over), .playerWon(player_won), .busy(busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Round-level model: which phase of a round we are in, plus the tallies.
  bit               m_load, m_run, m_score, m_over, m_won, m_pw, m_pl;
  int               m_win, m_lose;
  logic [WIDTH-1:0] m_ival;
  logic [1:0]       m_ctrl;

  task automatic model_step();
    bit rw, rl;
    rw = wnr && !m_pw;
    rl = lsr && !m_pl;
    m_pw = wnr;
    m_pl = lsr;
    if (rst) begin
      m_load = 0; m_run = 0; m_score = 0; m_over = 0; m_won = 0;
      m_pw = 0; m_pl = 0; m_win = 0; m_lose = 0; m_ival = '0; m_ctrl = '0;
      return;
    end
    m_ctrl = '0;
    if (m_load) begin
      m_load = 0; m_run = 1; m_ctrl = mode_sel;
    end else if (m_run) begin
      if (rw) begin m_win++; m_run = 0; m_score = 1; end
      else if (rl) begin m_lose++; m_run = 0; m_score = 1; end
      else m_ctrl = mode_sel;
    end else if (m_score) begin
      m_score = 0;
      if (m_win == TARGET) begin m_over = 1; m_won = 1; end
      else if (m_lose == TARGET) begin m_over = 1; m_won = 0; end
      else m_load = 1;
    end else if (start) begin
      m_ival = seed; m_win = 0; m_lose = 0; m_over = 0; m_won = 0; m_load = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; start = 0; wnr = 0; lsr = 0; mode_sel = 0; seed = 0;
    cycle();
    rst = 0;
  endtask

  // Start a game and advance until the round is running.
  task automatic begin_game(input logic [WIDTH-1:0] s);
    seed = s; start = 1;
    cycle();
    start = 0;
    cycle();
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst = 1; start = 1; seed = 4'd7; wnr = 0; lsr = 0; mode_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      cycle();
      obs = {cnt_if.controlValue, cnt_if.initialValue, cnt_if.INIT, win_score, lose_score,
             game_over, player_won, busy};
      n_total++;
      if (obs !== 18'd0) $display("FAIL reset_outputs cycle %0d: got %h want 0", i, obs);
      else n_pass++;
    end
    rst = 0; start = 0;
    cycle();
    n_total++;
    if (cnt_if.INIT !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_release_nostart: INIT=%b busy=%b want 0 0", cnt_if.INIT, busy);
    else n_pass++;
    rst = 1; start = 1;
    cycle();
    rst = 0;
    cycle();
    n_total++;
    if (cnt_if.INIT !== 1'b1 || cnt_if.initialValue !== 4'd7)
      $display("FAIL reset_release_start: INIT=%b init=%0d want 1 7", cnt_if.INIT, cnt_if.initialValue);
    else n_pass++;
    start = 0;
    cycle();
    n_total++;
    if (cnt_if.INIT !== 1'b0 || busy !== 1'b1)
      $display("FAIL reset_init_width: INIT=%b busy=%b want 0 1", cnt_if.INIT, busy);
    else n_pass++;
  endtask

  task automatic test_load_mode();
    do_reset();
    seed = 4'd10; start = 1;
    cycle();
    n_total++;
    if (cnt_if.INIT !== 1'b1 || cnt_if.initialValue !== 4'd10 || cnt_if.controlValue !== 2'd0)
      $display("FAIL load_init: INIT=%b init=%0d ctrl=%0d want 1 10 0",
               cnt_if.INIT, cnt_if.initialValue, cnt_if.controlValue);
    else n_pass++;
    start = 0; mode_sel = 2'd1;
    cycle();
    n_total++;
    if (cnt_if.INIT !== 1'b0 || cnt_if.controlValue !== 2'd1)
      $display("FAIL load_run_entry: INIT=%b ctrl=%0d want 0 1", cnt_if.INIT, cnt_if.controlValue);
    else n_pass++;
    for (int m = 2; m <= 3; m++) begin
      mode_sel = 2'(m);
      n_total++;
      if (cnt_if.controlValue !== 2'(m - 1))
        $display("FAIL mode_lag %0d: got %0d want %0d", m, cnt_if.controlValue, m - 1);
      else n_pass++;
      cycle();
      n_total++;
      if (cnt_if.controlValue !== 2'(m))
        $display("FAIL mode_follow %0d: got %0d want %0d", m, cnt_if.controlValue, m);
      else n_pass++;
    end
  endtask

  task automatic test_scoring_reload();
    int inits;
    do_reset();
    begin_game(4'd4);
    mode_sel = 2'd1;
    wnr = 1;
    inits = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      inits += int'(cnt_if.INIT);
      if (i == 0) begin
        n_total++;
        if (win_score !== 4'd1 || cnt_if.controlValue !== 2'd0)
          $display("FAIL score_tally: win=%0d ctrl=%0d want 1 0", win_score, cnt_if.controlValue);
        else n_pass++;
      end
      if (i == 1) begin
        n_total++;
        if (cnt_if.INIT !== 1'b1 || cnt_if.initialValue !== 4'd4)
          $display("FAIL score_reload: INIT=%b init=%0d want 1 4", cnt_if.INIT, cnt_if.initialValue);
        else n_pass++;
      end
    end
    wnr = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      inits += int'(cnt_if.INIT);
    end
    n_total++;
    if (inits != 1 || win_score !== 4'd1)
      $display("FAIL score_no_double: inits=%0d win=%0d want 1 1", inits, win_score);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    begin_game(4'd6);
    wnr = 1; lsr = 1;
    cycle();
    n_total++;
    if (win_score !== 4'd1 || lose_score !== 4'd0)
      $display("FAIL simul_flags: win=%0d lose=%0d want 1 0", win_score, lose_score);
    else n_pass++;
    wnr = 0; lsr = 0;
    cycle(); cycle();
    lsr = 1;
    cycle();
    n_total++;
    if (win_score !== 4'd1 || lose_score !== 4'd1)
      $display("FAIL simul_then_lose: win=%0d lose=%0d want 1 1", win_score, lose_score);
    else n_pass++;
    lsr = 0;
    cycle(); cycle();
  endtask

  task automatic test_game_end();
    int inits;
    do_reset();
    begin_game(4'd9);
    for (int r = 1; r <= TARGET; r++) begin
      lsr = 1;
      cycle();
      n_total++;
      if (lose_score !== 4'(r)) $display("FAIL end_tally %0d: got %0d want %0d", r, lose_score, r);
      else n_pass++;
      lsr = 0;
      cycle();
      if (r < TARGET) cycle();
    end
    n_total++;
    if (game_over !== 1'b1 || player_won !== 1'b0 || busy !== 1'b0 || lose_score !== 4'd3)
      $display("FAIL end_over: over=%b won=%b busy=%b lose=%0d want 1 0 0 3",
               game_over, player_won, busy, lose_score);
    else n_pass++;
    inits = 0;
    for (int i = 0; i < 4; i++) begin
      lsr = (i % 2 == 0);
      cycle();
      inits += int'(cnt_if.INIT);
    end
    lsr = 0;
    n_total++;
    if (inits != 0 || lose_score !== 4'd3 || game_over !== 1'b1)
      $display("FAIL end_hold: inits=%0d lose=%0d over=%b want 0 3 1", inits, lose_score, game_over);
    else n_pass++;
    seed = 4'd5; start = 1;
    cycle();
    start = 0;
    n_total++;
    if (win_score !== 4'd0 || lose_score !== 4'd0 || cnt_if.INIT !== 1'b1 ||
        cnt_if.initialValue !== 4'd5 || game_over !== 1'b0)
      $display("FAIL end_restart: win=%0d lose=%0d INIT=%b init=%0d over=%b want 0 0 1 5 0",
               win_score, lose_score, cnt_if.INIT, cnt_if.initialValue, game_over);
    else n_pass++;
    cycle();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    begin_game(4'd3);
    for (int r = 0; r < 2; r++) begin
      wnr = 1; cycle();
      wnr = 0; cycle(); cycle();
    end
    mode_sel = 2'd3;
    cycle();
    n_total++;
    if (win_score !== 4'd2 || busy !== 1'b1 || cnt_if.controlValue !== 2'd3)
      $display("FAIL midrun_pre: win=%0d busy=%b ctrl=%0d want 2 1 3", win_score, busy, cnt_if.controlValue);
    else n_pass++;
    rst = 1;
    cycle();
    rst = 0;
    n_total++;
    if (win_score !== 4'd0 || lose_score !== 4'd0 || cnt_if.controlValue !== 2'd0 ||
        busy !== 1'b0 || cnt_if.INIT !== 1'b0 || game_over !== 1'b0)
      $display("FAIL midrun_reset: win=%0d lose=%0d ctrl=%0d busy=%b INIT=%b over=%b want all 0",
               win_score, lose_score, cnt_if.controlValue, busy, cnt_if.INIT, game_over);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [17:0] obs, exp;
    int          bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 3) == 0);
      seed     = 4'($urandom);
      mode_sel = 2'($urandom);
      if ($urandom_range(0, 2) == 0) wnr = ~wnr;
      if ($urandom_range(0, 2) == 0) lsr = ~lsr;
      cycle();
      obs = {cnt_if.controlValue, cnt_if.initialValue, cnt_if.INIT, win_score, lose_score,
             game_over, player_won, busy};
      exp = {m_ctrl, m_ival, m_load, 4'(m_win), 4'(m_lose), m_over, m_won,
             (m_load | m_run | m_score)};
      n_total++;
      if (obs !== exp) begin
        if (bad < 10) $display("FAIL random cycle %0d: got %h want %h", i, obs, exp);
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    rst = 1; start = 0; wnr = 0; lsr = 0; mode_sel = 0; seed = 0;
    test_reset();
    test_load_mode();
    test_scoring_reload();
    test_simultaneous();
    test_game_end();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
